// File: rtl/uart_calc_core.sv
// uart_calc_core: line-oriented decimal calculator sitting between a UART
// receiver and transmitter. Bytes build an optional operator plus operand;
// CR applies it to a signed accumulator and the result is streamed back
// as an ASCII line.
module uart_calc_core #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 4,
  parameter int ECHO   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [WIDTH-1:0] acc,
  output logic             err
);

  // ceil(WIDTH * log10(2)) decimal digits cover |most negative value|
  localparam int NSTK = (WIDTH * 30103 + 99999) / 100000;
  localparam int SCW  = $clog2(NSTK + 1);
  localparam int DCW  = $clog2(DIGITS + 1);
  localparam int MW   = WIDTH + 1;
  localparam int XW   = 34;

  typedef enum logic [2:0] {S_IDLE, S_ECHO, S_PARSE, S_EXEC, S_CONV, S_SEND} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
  typedef enum logic [2:0] {ST_CR1, ST_LF1, ST_SIGN, ST_DIG, ST_ERR, ST_CR2, ST_LF2} step_t;

  state_t         state, state_next;
  op_t            op, rx_op;
  step_t          step, step_next;
  logic [3:0]     dbuf [DIGITS];
  logic [DCW-1:0] dcnt, pidx;
  logic [31:0]    operand;
  logic [MW-1:0]  mag;
  logic [3:0]     stk [NSTK];
  logic [SCW-1:0] scnt;
  logic [1:0]     ecnt;

  logic           is_digit, is_op, is_bs, is_clr, is_cr;
  logic           take_digit, take_op, take_bs, take_echo;
  logic           xfer, div0, parse_last, conv_last, send_last;
  logic [3:0]     cur_digit, top_digit, new_digit;
  logic [XW-1:0]  acc_x;
  logic [WIDTH-1:0] exec_val;
  logic [MW-1:0]  mag_new, mag_div;
  logic [7:0]     byte_next;
  logic [SCW-1:0] scnt_next;
  logic [1:0]     ecnt_next;

  // Classify the received byte and decide whether it edits the line.
  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_bs    = (rx_data == 8'h08);
    is_clr   = (rx_data == 8'h63) || (rx_data == 8'h43);
    is_cr    = (rx_data == 8'h0D);
    case (rx_data)
      8'h2B:   rx_op = OP_ADD;
      8'h2D:   rx_op = OP_SUB;
      8'h2A:   rx_op = OP_MUL;
      8'h2F:   rx_op = OP_DIV;
      default: rx_op = OP_NONE;
    endcase
    is_op      = (rx_op != OP_NONE);
    take_digit = is_digit && (dcnt < DCW'(DIGITS));
    take_op    = is_op && (dcnt == {DCW{1'b0}}) && (op == OP_NONE);
    take_bs    = is_bs && ((dcnt != {DCW{1'b0}}) || (op != OP_NONE));
    take_echo  = take_digit || take_op || take_bs;
    xfer       = tx_valid && tx_ready;
  end

  // Select the digit being parsed and the top of the result digit stack.
  always_comb begin
    cur_digit = 4'd0;
    top_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_digit = (DCW'(i) == pidx) ? dbuf[i] : cur_digit;
    end
    for (int i = 0; i < NSTK; i++) begin
      top_digit = (SCW'(i) == (scnt - SCW'(1))) ? stk[i] : top_digit;
    end
    parse_last = (dcnt == {DCW{1'b0}}) || (pidx == (dcnt - DCW'(1)));
    mag_div    = mag / MW'(10);
    new_digit  = 4'(mag % MW'(10));
    conv_last  = (mag_div == {MW{1'b0}});
  end

  // Arithmetic applied on EXEC and the magnitude of its result.
  always_comb begin
    acc_x = {{(XW-WIDTH){acc[WIDTH-1]}}, acc};
    div0  = (op == OP_DIV) && (operand == 32'd0);
    case (op)
      OP_NONE: exec_val = operand[WIDTH-1:0];
      OP_ADD:  exec_val = acc + operand[WIDTH-1:0];
      OP_SUB:  exec_val = acc - operand[WIDTH-1:0];
      OP_MUL:  exec_val = acc * operand[WIDTH-1:0];
      OP_DIV:  exec_val = div0 ? acc : WIDTH'($signed(acc_x) / $signed({2'b00, operand}));
      default: exec_val = acc;
    endcase
    // Extra bit keeps the most-negative value's magnitude representable
    mag_new = exec_val[WIDTH-1] ? (~{1'b1, exec_val} + MW'(1)) : {1'b0, exec_val};
  end

  // Byte sequencer for the result line: CRLF, sign/digits or ERR, CRLF.
  always_comb begin
    step_next = step;
    byte_next = tx_data;
    scnt_next = scnt;
    ecnt_next = ecnt;
    case (step)
      ST_CR1: begin
        step_next = ST_LF1;
        byte_next = 8'h0A;
      end
      ST_LF1: begin
        if (err) begin
          step_next = ST_ERR;
          byte_next = 8'h45;
          ecnt_next = 2'd1;
        end else if (acc[WIDTH-1]) begin
          step_next = ST_SIGN;
          byte_next = 8'h2D;
        end else begin
          step_next = ST_DIG;
          byte_next = {4'h3, top_digit};
          scnt_next = scnt - SCW'(1);
        end
      end
      ST_SIGN: begin
        step_next = ST_DIG;
        byte_next = {4'h3, top_digit};
        scnt_next = scnt - SCW'(1);
      end
      ST_DIG: begin
        if (scnt == {SCW{1'b0}}) begin
          step_next = ST_CR2;
          byte_next = 8'h0D;
        end else begin
          byte_next = {4'h3, top_digit};
          scnt_next = scnt - SCW'(1);
        end
      end
      ST_ERR: begin
        if (ecnt == 2'd3) begin
          step_next = ST_CR2;
          byte_next = 8'h0D;
        end else begin
          byte_next = 8'h52;
          ecnt_next = ecnt + 2'd1;
        end
      end
      ST_CR2: begin
        step_next = ST_LF2;
        byte_next = 8'h0A;
      end
      ST_LF2: begin
        step_next = ST_CR1;
      end
      default: begin
        step_next = ST_CR1;
        byte_next = 8'h0D;
      end
    endcase
    send_last = (step == ST_LF2);
  end

  // Next-state logic of the main controller.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!rx_valid) begin
          state_next = S_IDLE;
        end else if (is_cr) begin
          state_next = S_PARSE;
        end else if (is_clr) begin
          state_next = S_SEND;
        end else if (take_echo && (ECHO != 32'sd0)) begin
          state_next = S_ECHO;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ECHO:  state_next = xfer ? S_IDLE : S_ECHO;
      S_PARSE: state_next = parse_last ? S_EXEC : S_PARSE;
      S_EXEC:  state_next = div0 ? S_SEND : S_CONV;
      S_CONV:  state_next = conv_last ? S_SEND : S_CONV;
      S_SEND:  state_next = (xfer && send_last) ? S_IDLE : S_SEND;
      default: state_next = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: line buffer, accumulator, conversion stack and tx register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      acc      <= {WIDTH{1'b0}};
      err      <= 1'b0;
      op       <= OP_NONE;
      dcnt     <= {DCW{1'b0}};
      pidx     <= {DCW{1'b0}};
      operand  <= 32'd0;
      mag      <= {MW{1'b0}};
      scnt     <= {SCW{1'b0}};
      ecnt     <= 2'd0;
      step     <= ST_CR1;
      for (int i = 0; i < DIGITS; i++) dbuf[i] <= 4'd0;
      for (int i = 0; i < NSTK; i++) stk[i] <= 4'd0;
    end else begin
      busy <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if (is_cr) begin
              operand <= 32'd0;
              pidx    <= {DCW{1'b0}};
              err     <= 1'b0;
            end else if (is_clr) begin
              acc      <= {WIDTH{1'b0}};
              err      <= 1'b0;
              dcnt     <= {DCW{1'b0}};
              op       <= OP_NONE;
              stk[0]   <= 4'd0;
              scnt     <= SCW'(1);
              step     <= ST_CR1;
              tx_data  <= 8'h0D;
              tx_valid <= 1'b1;
            end else begin
              if (take_digit) begin
                for (int i = 0; i < DIGITS; i++) begin
                  if (DCW'(i) == dcnt) dbuf[i] <= rx_data[3:0];
                end
                dcnt <= dcnt + DCW'(1);
              end
              if (take_op) op <= rx_op;
              if (take_bs) begin
                if (dcnt != {DCW{1'b0}}) dcnt <= dcnt - DCW'(1);
                else op <= OP_NONE;
              end
              if (take_echo && (ECHO != 32'sd0)) begin
                tx_data  <= rx_data;
                tx_valid <= 1'b1;
              end
            end
          end
        end
        S_ECHO: begin
          if (xfer) tx_valid <= 1'b0;
        end
        S_PARSE: begin
          if (dcnt != {DCW{1'b0}}) operand <= operand * 32'd10 + {28'd0, cur_digit};
          pidx <= pidx + DCW'(1);
        end
        S_EXEC: begin
          if (div0) begin
            err      <= 1'b1;
            step     <= ST_CR1;
            tx_data  <= 8'h0D;
            tx_valid <= 1'b1;
          end else begin
            acc  <= exec_val;
            mag  <= mag_new;
            scnt <= {SCW{1'b0}};
          end
        end
        S_CONV: begin
          for (int i = 0; i < NSTK; i++) begin
            if (SCW'(i) == scnt) stk[i] <= new_digit;
          end
          scnt <= scnt + SCW'(1);
          mag  <= mag_div;
          if (conv_last) begin
            step     <= ST_CR1;
            tx_data  <= 8'h0D;
            tx_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (xfer) begin
            step <= step_next;
            scnt <= scnt_next;
            ecnt <= ecnt_next;
            if (send_last) begin
              tx_valid <= 1'b0;
              dcnt     <= {DCW{1'b0}};
              op       <= OP_NONE;
            end else begin
              tx_data <= byte_next;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_calc_core.sv
// Directed bench for uart_calc_core: a 32-bit/4-digit instance with echo and
// an 8-bit/2-digit instance, driven through hand-computed calculator lines.
module tb_uart_calc_core;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data32, tx_data32, rx_data8, tx_data8;
  logic        rx_valid32, tx_valid32, tx_ready32, busy32, err32;
  logic        rx_valid8, tx_valid8, tx_ready8, busy8, err8;
  logic [31:0] acc32;
  logic [7:0]  acc8;
  logic [7:0]  q32[$];
  logic [7:0]  q8[$];
  int          vectors = 0;
  int          miscompares = 0;

  uart_calc_core #(.WIDTH(32), .DIGITS(4), .ECHO(1)) dut32 (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data32), .rx_valid(rx_valid32),
    .tx_data(tx_data32), .tx_valid(tx_valid32), .tx_ready(tx_ready32),
    .busy(busy32), .acc(acc32), .err(err32)
  );

  uart_calc_core #(.WIDTH(8), .DIGITS(2), .ECHO(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .busy(busy8), .acc(acc8), .err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every transferred byte of both instances.
  always @(negedge clk) begin
    if (tx_valid32 && tx_ready32) q32.push_back(tx_data32);
    if (tx_valid8 && tx_ready8) q8.push_back(tx_data8);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit to8, input logic [7:0] b);
    int n;
    n = 0;
    while ((to8 ? busy8 : busy32) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle before send", 32'(n < 500), 32'd1);
    @(posedge clk); #1;
    if (to8) begin
      rx_data8 = b; rx_valid8 = 1'b1;
    end else begin
      rx_data32 = b; rx_valid32 = 1'b1;
    end
    @(posedge clk); #1;
    rx_valid8 = 1'b0; rx_valid32 = 1'b0;
  endtask

  task automatic clear_q();
    q32.delete();
    q8.delete();
  endtask

  task automatic wait_tx_valid32(output int lat);
    lat = 1;
    while (!tx_valid32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Expected stream: echoed bytes, then CR LF body CR LF.
  task automatic expect_out(input bit from8, input string tag, input string echo, input string body);
    logic [7:0] exp_q[$];
    logic [7:0] got;
    int waited;
    int qs;
    exp_q = {};
    for (int i = 0; i < echo.len(); i++) exp_q.push_back(echo[i]);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    waited = 0;
    qs = from8 ? q8.size() : q32.size();
    while (qs < exp_q.size() && waited < 3000) begin
      @(negedge clk);
      waited++;
      qs = from8 ? q8.size() : q32.size();
    end
    repeat (4) @(negedge clk);
    qs = from8 ? q8.size() : q32.size();
    check($sformatf("%s count", tag), 32'(qs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 8'h00;
      if (i < qs) got = from8 ? q8[i] : q32[i];
      check($sformatf("%s[%0d]", tag, i), {24'd0, got}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    int lat;
    logic [7:0] held;
    bit stable;
    string e;

    reset_n = 1'b0;
    rx_data32 = 8'h00; rx_valid32 = 1'b0; tx_ready32 = 1'b1;
    rx_data8 = 8'h00; rx_valid8 = 1'b0; tx_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst tx_valid", {31'd0, tx_valid32}, 32'd0);
    check("rst tx_data", {24'd0, tx_data32}, 32'h00);
    check("rst busy", {31'd0, busy32}, 32'd0);
    check("rst acc", acc32, 32'd0);
    check("rst err", {31'd0, err32}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post-rst busy", {31'd0, busy32}, 32'd0);

    // Load 12
    clear_q();
    send(1'b0, 8'h31);
    check("echo latency valid", {31'd0, tx_valid32}, 32'd1);
    check("echo latency data", {24'd0, tx_data32}, 32'h31);
    check("busy after echo", {31'd0, busy32}, 32'd1);
    send(1'b0, 8'h32);
    send(1'b0, 8'h0D);
    wait_tx_valid32(lat);
    check("cr latency 12", 32'(lat), 32'd6);
    expect_out(1'b0, "load12", "12", "12");
    check("acc 12", acc32, 32'd12);

    // Multiply by 3
    clear_q();
    send(1'b0, 8'h2A); send(1'b0, 8'h33); send(1'b0, 8'h0D);
    expect_out(1'b0, "mul3", "*3", "36");
    check("acc 36", acc32, 32'd36);

    // Subtract 50 entered with a backspace
    clear_q();
    send(1'b0, 8'h2D); send(1'b0, 8'h35); send(1'b0, 8'h30);
    send(1'b0, 8'h08); send(1'b0, 8'h30); send(1'b0, 8'h0D);
    e = "-50x0";
    e.putc(3, 8'h08);
    expect_out(1'b0, "sub50", e, "-14");
    check("acc -14", acc32, 32'hFFFF_FFF2);

    // Divide by zero
    clear_q();
    send(1'b0, 8'h2F); send(1'b0, 8'h30); send(1'b0, 8'h0D);
    wait_tx_valid32(lat);
    check("cr latency err", 32'(lat), 32'd3);
    expect_out(1'b0, "div0", "/0", "ERR");
    check("err set", {31'd0, err32}, 32'd1);
    check("acc kept", acc32, 32'hFFFF_FFF2);

    // Clear
    clear_q();
    send(1'b0, 8'h63);
    expect_out(1'b0, "clear", "", "0");
    check("err cleared", {31'd0, err32}, 32'd0);
    check("acc cleared", acc32, 32'd0);

    // 8-bit instance: digit limit then wrapping multiply
    clear_q();
    send(1'b1, 8'h31); send(1'b1, 8'h32); send(1'b1, 8'h33); send(1'b1, 8'h0D);
    expect_out(1'b1, "limit", "12", "12");
    check("acc8 12", {24'd0, acc8}, 32'd12);
    clear_q();
    send(1'b1, 8'h2A); send(1'b1, 8'h31); send(1'b1, 8'h31); send(1'b1, 8'h0D);
    expect_out(1'b1, "wrap", "*11", "-124");
    check("acc8 -124", {24'd0, acc8}, 32'h84);

    // Stalled transmitter with a byte strobed while busy
    clear_q();
    send(1'b0, 8'h34); send(1'b0, 8'h32);
    @(posedge clk); #1;
    tx_ready32 = 1'b0;
    send(1'b0, 8'h0D);
    wait_tx_valid32(lat);
    held = tx_data32;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin rx_data32 = 8'h37; rx_valid32 = 1'b1; end
      if (i == 11) rx_valid32 = 1'b0;
      if (tx_data32 !== held || tx_valid32 !== 1'b1) stable = 1'b0;
    end
    check("stall held byte", {24'd0, held}, 32'h0D);
    check("stall stable", {31'd0, stable}, 32'd1);
    check("stall busy", {31'd0, busy32}, 32'd1);
    tx_ready32 = 1'b1;
    expect_out(1'b0, "stall", "42", "42");
    check("acc 42", acc32, 32'd42);
    clear_q();
    send(1'b0, 8'h2B); send(1'b0, 8'h31); send(1'b0, 8'h0D);
    expect_out(1'b0, "after drop", "+1", "43");
    check("acc 43", acc32, 32'd43);

    // Reset while the third result byte is pending
    clear_q();
    send(1'b0, 8'h39);
    @(posedge clk); #1;
    tx_ready32 = 1'b0;
    send(1'b0, 8'h0D);
    wait_tx_valid32(lat);
    tx_ready32 = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    tx_ready32 = 1'b0;
    check("pending byte", {24'd0, tx_data32}, 32'h39);
    check("pending valid", {31'd0, tx_valid32}, 32'd1);
    check("acc 9", acc32, 32'd9);
    reset_n = 1'b0;
    #1;
    check("midrst tx_valid", {31'd0, tx_valid32}, 32'd0);
    check("midrst acc", acc32, 32'd0);
    check("midrst busy", {31'd0, busy32}, 32'd0);
    #2;
    reset_n = 1'b1;
    tx_ready32 = 1'b1;
    clear_q();
    send(1'b0, 8'h35); send(1'b0, 8'h0D);
    expect_out(1'b0, "post reset", "5", "5");
    check("acc 5", acc32, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_calc_core.md
# uart_calc_core

Parametrised calculator engine between `uart_rx` and `uart_tx`. It parses received ASCII into an optional operator plus a decimal operand, and applies the operator to a signed accumulator on carriage return. It then streams the result back as a decimal ASCII line. Accumulator width, operand digit limit and echo are configurable, and the block adds backspace editing, clear, divide-by-zero error reporting and a ready/valid transmit handshake.

## Interface
- `WIDTH`, 32: accumulator/result width in bits, signed two's complement; legal range 8..32.
- `DIGITS`, 4: maximum operand digits kept per line; legal range 1..9.
- `ECHO`, 1: 1 = echo each accepted input byte; 0 = no echo.
- `clk` in 1: single clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte; valid only while `rx_valid` = 1.
- `rx_valid` in 1: one-cycle strobe, new byte present.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` holds a byte to send.
- `tx_ready` in 1: transmitter can accept. A byte transfers on a cycle where `tx_valid & tx_ready` = 1.
- `busy` out 1: 1 in every state except IDLE. Bytes strobed while `busy` = 1 are dropped.
- `acc` out WIDTH: current accumulator value.
- `err` out 1: set by a divide by zero; cleared by the next accepted CR or clear.

## Operation
- **States:** IDLE, ECHO, PARSE, EXEC, CONV, SEND.
- **IDLE, on `rx_valid`:**
  - `0`–`9`: appended to the digit buffer if count < `DIGITS`; otherwise ignored and not echoed.
  - `+ - * /`: latched as the line operator, only when the digit count is 0 and no operator is held yet; otherwise ignored.
  - `0x08` backspace: removes the last digit. If there are no digits, it removes the operator. If there is neither, it is ignored.
  - `c`/`C`: acc := 0, buffer and operator cleared, result line queued.
  - `0x0D` (CR): go to PARSE.
  - Any other byte: ignored.
  - Accepted non-CR bytes go to ECHO when `ECHO` = 1; otherwise stay in IDLE.
- **ECHO:** presents the accepted byte. On transfer, returns to IDLE.
- **PARSE:** operand := operand*10 + digit, one digit per cycle, MSB first. With zero digits the operand is 0.
- **EXEC:** one cycle.
  - No operator: acc := operand.
  - `+`, `-`, `*`: acc := acc op operand, truncated to WIDTH bits (wraps, no saturation).
  - `/`: signed division, truncating toward zero.
  - `/` with operand 0: acc unchanged, `err` := 1.
- **CONV:**
  - Magnitude |acc| is computed in WIDTH+1 bits, so the most-negative value converts correctly.
  - One decimal digit is produced per cycle by /10 and %10 into a digit stack of ceil(WIDTH·log10 2) entries.
  - At least one digit is always produced (0 → "0").
- **SEND:** emits `0x0D 0x0A`, then `-` if acc < 0, then the digits MSB first, then `0x0D 0x0A`.
  - On error it emits `0x0D 0x0A E R R 0x0D 0x0A` instead.
  - Then the digit buffer and operator are cleared and the state returns to IDLE.
- Clear enters SEND with acc = 0 and skips PARSE and EXEC.

## Timing
- **Reset values:** `tx_valid` = 0, `tx_data` = 0x00, `busy` = 0, `acc` = 0, `err` = 0, state = IDLE, buffer and operator empty.
- **Echo latency:** `tx_valid` rises on the cycle after the `rx_valid` cycle.
- **`tx_valid` hold rule:** once raised, `tx_valid` stays high and `tx_data` stays stable until a transfer. The next byte may be presented on the cycle after the transfer.
- **CR to first response byte:** max(n,1) PARSE cycles + 1 EXEC cycle + k CONV cycles + 1, where n = digits and k = result digits. The error path uses k = 0.
- `busy` is registered and rises on the cycle after the accepted CR or echoed byte.
- `rx_valid` arriving on the same cycle that SEND or ECHO finishes is dropped.
- `tx_ready` held low stalls indefinitely with no loss of state.
- **Reset mid-operation:** `reset_n` low clears all outputs immediately, including `tx_valid` in the middle of a byte. Any partial line is discarded.

## Test plan
- **Load, then multiply** (WIDTH=32, DIGITS=4, ECHO=1): send `1`,`2`,CR.
  - Required: echoes `1`,`2`, then `0D 0A 31 32 0D 0A`; acc = 12.
  - Then `*3`,CR → line "36"; acc = 36.
- **Negative result and backspace:** acc = 36, send `-`,`5`,`0`,`0x08`,`0`,CR.
  - Required: operand is 50; line `0D 0A 2D 31 34 0D 0A` ("-14"); acc = -14.
- **Divide by zero, then recovery:** send `/`,`0`,CR.
  - Required: `0D 0A 45 52 52 0D 0A`, `err` = 1, acc unchanged.
  - Then `c` → line "0", `err` = 0.
- **Digit limit and wrap** (WIDTH=8, DIGITS=2): send `1`,`2`,`3`,CR.
  - Required: `3` is not echoed; acc = 12.
  - Then `*`,`1`,`1`,CR → 132 wraps to -124; line "-124".
- **Handshake stall and dropped input:** hold `tx_ready` = 0 for 50 cycles during SEND and strobe `rx_valid` with `7`.
  - Required: `tx_data` stable throughout; the `7` is dropped and the next line starts with an empty buffer.
- **Reset mid-send:** assert `reset_n` = 0 while the third result byte is pending.
  - Required: `tx_valid` = 0, `acc` = 0, `busy` = 0 immediately.
  - After release, `5`,CR → line "5".
